regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port register file; successor to the 16x8 1W2R file. Configurable width,
//   depth, read-port count, two write ports with fixed priority, optional hardwired zero entry,
//   and a cycle-swept synchronous clear with busy handshake. Sits in the datapath between decode
//   (read addresses) and writeback (write ports).
// PARAMETERS
//   DATA_W    8                 entry width in bits
//   DEPTH     16                number of entries, >= 2, need not be a power of 2
//   ADDR_W    $clog2(DEPTH)     address width (derived, do not override)
//   NUM_RD    2                 number of combinational read ports, >= 1
//   ZERO_REG  1                 1: entry 0 reads 0 and ignores writes; 0: entry 0 is ordinary
// PORTS
//   clk          in   1               clock, all state on posedge
//   rst_n        in   1               asynchronous active-low reset
//   clk_en       in   1               global enable; low freezes all state, including the clear sweep
//   wr_en        in   2               per-write-port enable, [0] = high-priority port
//   wr_addr      in   2*ADDR_W        write addresses, port p at [p*ADDR_W +: ADDR_W]
//   wr_data      in   2*DATA_W        write data, port p at [p*DATA_W +: DATA_W]
//   wr_ready     out  1               1 = writes accepted this cycle
//   wr_conflict  out  1               registered 1-cycle pulse: both ports wrote the same address
//   rd_addr      in   NUM_RD*ADDR_W   read addresses, packed as for wr_addr
//   rd_data      out  NUM_RD*DATA_W   read data, combinational from rd_addr
//   clear_req    in   1               request a full clear, sampled in IDLE
//   clear_busy   out  1               1 while the clear sweep is running
// BEHAVIOUR
//   Reset (rst_n=0, async): every entry 0, FSM IDLE, clear_busy=0, wr_ready=1, wr_conflict=0.
//   Write: entry updates at posedge when clk_en & wr_en[p] & wr_ready; visible on rd_data next cycle.
//   Conflict: both ports enabled, same address -> port 0 data stored, port 1 dropped,
//     wr_conflict=1 for the following cycle (only if the write was accepted).
//   Address >= DEPTH: writes dropped (no conflict flag), reads return 0.
//   ZERO_REG=1: writes to address 0 dropped, reads of address 0 return 0 on every port.
//   Reads: NUM_RD independent ports; same address on several ports returns identical data.
//   FSM states: IDLE, CLEAR.
//     IDLE  -> CLEAR  on clk_en & clear_req; sweep pointer loads 0 (1 when ZERO_REG=1).
//     CLEAR: each clk_en cycle zeroes entry[ptr], ptr++; entry DEPTH-1 zeroed -> IDLE same edge.
//     clk_en=0 in CLEAR: pointer and state hold.
//   clear_busy = (state==CLEAR); wr_ready = !clear_busy, combinational from state.
//   Writes presented while wr_ready=0 are dropped; clear_req while busy is ignored (no restart).
//   Reads during CLEAR return current contents: swept entries 0, unswept entries old values.
//   Clear of DEPTH entries takes DEPTH cycles (DEPTH-1 with ZERO_REG) of clk_en high.
//   rst_n asserted mid-sweep: immediate return to IDLE with all entries 0.
//   Write and clear_req in the same IDLE cycle: write is performed, sweep starts next cycle.
// CONFIGURATION
//   Macro REGFILE_BYPASS_EN.
//   Defined: rd_data forwards an accepted same-cycle write whose address matches rd_addr
//     (port 0 wins on conflict); never forwards to address 0 when ZERO_REG=1, nor while clear_busy.
//   Undefined: rd_data always shows stored contents; written data appears the cycle after.
// STRUCTURE
//   regfile_pkg: typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_e; NUM_WR=2 constant;
//     function for packed-slice extraction shared by read/write ports.
//   Sub-module regfile_clear_fsm: state register, sweep pointer, clear_busy/wr_ready, pointer-valid
//     strobe; parameters DEPTH, ZERO_REG. Storage, write arbitration and read muxes stay in top.
// TESTING
//   1 Reset, write 0xA5 to addr 3 via port 0 -> rd_data[0]=0x00 same cycle, 0xA5 next cycle.
//   2 Ports 0 and 1 both write addr 5 (0x11, 0x22) -> entry 5 = 0x11, wr_conflict=1 one cycle.
//   3 ZERO_REG=1, write 0xFF to addr 0 -> all read ports at addr 0 return 0x00.
//   4 Fill all 16 entries, pulse clear_req -> clear_busy high 15 cycles, write during sweep dropped,
//     all entries 0 afterwards.
//   5 Drop clk_en for 3 cycles mid-sweep -> pointer holds, sweep ends 3 cycles later; rst_n low
//     mid-sweep -> clear_busy=0 immediately.
//   6 REGFILE_BYPASS_EN: write 0x3C to addr 7 with rd_addr=7 -> rd_data=0x3C same cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Optional same-cycle read bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    typedef enum logic {
        RF_IDLE,
        RF_CLEAR
    } rf_state_e;

    localparam int NUM_WR      = 2;
    localparam int SLICE_W     = 64;
    localparam int SLICE_VEC_W = 512;

    // Extracts field idx of width w from a packed port vector.
    function automatic logic [SLICE_W-1:0] get_slice(
        input logic [SLICE_VEC_W-1:0] vec,
        input int unsigned            idx,
        input int unsigned            w
    );
        logic [SLICE_VEC_W-1:0] sh;
        sh = vec >> (idx * w);
        return sh[SLICE_W-1:0];
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write/read/clear bus of the multi-port register file.
// The REGFILE_BYPASS_EN build uses the same bus unchanged.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
);
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     wr_ready;
    logic                     wr_conflict;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     clear_req;
    logic                     clear_busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, clear_req,
        input  wr_ready, wr_conflict, rd_data, clear_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, clear_req,
        output wr_ready, wr_conflict, rd_data, clear_busy
    );
endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear sweep controller: walks every entry once, blocking writes meanwhile.
// Behaviour does not depend on REGFILE_BYPASS_EN.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter  int DEPTH    = 16,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              wr_ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_ptr
);
    localparam logic [ADDR_W-1:0] PTR_FIRST =
        (ZERO_REG != 0) ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    rf_state_e state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RF_IDLE;
            clr_ptr <= '0;
        end else if (clk_en) begin
            unique case (state)
                RF_IDLE: begin
                    if (clear_req) begin
                        state   <= RF_CLEAR;
                        clr_ptr <= PTR_FIRST;
                    end
                end
                RF_CLEAR: begin
                    clr_ptr <= clr_ptr + ADDR_W'(1);
                    if (clr_ptr == PTR_LAST)
                        state <= RF_IDLE;
                end
                default: state <= RF_IDLE;
            endcase
        end
    end

    assign clear_busy = (state == RF_CLEAR);
    assign wr_ready   = !clear_busy;
    assign clr_we     = clear_busy & clk_en;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised 2W/NUM_RD-R register file with priority writes and swept clear.
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int DEPTH    = 16,
    parameter  int NUM_RD   = 2,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input logic         clk,
    input logic         rst_n,
    input logic         clk_en,
    regfile_mp_if.slave bus
);
    logic [DATA_W-1:0] mem [DEPTH];

    logic [NUM_WR-1:0][ADDR_W-1:0] wa;
    logic [NUM_WR-1:0][DATA_W-1:0] wd;
    logic [NUM_WR-1:0]             acc;
    logic [NUM_RD-1:0][ADDR_W-1:0] ra;
    logic                          ready;
    logic                          busy;
    logic                          clr_we;
    logic [ADDR_W-1:0]             clr_ptr;
    logic                          hit;

    // Entries that really hold data: in range and not the hardwired zero.
    function automatic logic live(input logic [ADDR_W-1:0] a);
        return (32'(a) < DEPTH) && !(ZERO_REG != 0 && a == '0);
    endfunction

    regfile_clear_fsm #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_clear (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .clear_req  (bus.clear_req),
        .clear_busy (busy),
        .wr_ready   (ready),
        .clr_we     (clr_we),
        .clr_ptr    (clr_ptr)
    );

    assign bus.wr_ready   = ready;
    assign bus.clear_busy = busy;

    always_comb begin
        wa  = '0;
        wd  = '0;
        acc = '0;
        for (int unsigned p = 0; p < NUM_WR; p++) begin
            wa[p] = ADDR_W'(get_slice(
                SLICE_VEC_W'(bus.wr_addr), p, ADDR_W));
            wd[p] = DATA_W'(get_slice(
                SLICE_VEC_W'(bus.wr_data), p, DATA_W));
            acc[p] = clk_en & bus.wr_en[p] & ready & live(wa[p]);
        end
    end

    assign hit = acc[0] & acc[1] & (wa[0] == wa[1]);

    // Port 0 is written last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            bus.wr_conflict <= 1'b0;
        end else if (clk_en) begin
            bus.wr_conflict <= hit;
            if (clr_we)
                mem[clr_ptr] <= '0;
            if (acc[1])
                mem[wa[1]] <= wd[1];
            if (acc[0])
                mem[wa[0]] <= wd[0];
        end
    end

    always_comb begin
        ra = '0;
        for (int unsigned r = 0; r < NUM_RD; r++)
            ra[r] = ADDR_W'(get_slice(
                SLICE_VEC_W'(bus.rd_addr), r, ADDR_W));
    end

    always_comb begin
        bus.rd_data = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            if (live(ra[r]))
                bus.rd_data[r*DATA_W +: DATA_W] = mem[ra[r]];
`ifdef REGFILE_BYPASS_EN
            if (acc[1] && wa[1] == ra[r])
                bus.rd_data[r*DATA_W +: DATA_W] = wd[1];
            if (acc[0] && wa[0] == ra[r])
                bus.rd_data[r*DATA_W +: DATA_W] = wd[0];
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (16x8, 2 read ports, zero reg).
// Build with REGFILE_BYPASS_EN defined to also cover the read bypass.
module tb_regfile_mp;
    logic clk;
    logic rst_n;
    logic clk_en;
    int   errors;
    int   checks;

    regfile_mp_if #(.DATA_W(8), .ADDR_W(4), .NUM_RD(2)) bus ();

    regfile_mp #(
        .DATA_W   (8),
        .DEPTH    (16),
        .NUM_RD   (2),
        .ZERO_REG (1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_wr(input logic [1:0] en,
                          input logic [3:0] a1, input logic [7:0] d1,
                          input logic [3:0] a0, input logic [7:0] d0);
        bus.wr_en   = en;
        bus.wr_addr = {a1, a0};
        bus.wr_data = {d1, d0};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clk_en = 1'b1;
        set_wr(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
        bus.rd_addr = {4'd5, 4'd3};
        bus.clear_req = 1'b0;
        #12;
        checks++;
        if (bus.clear_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b exp 0", bus.clear_busy);
        end
        checks++;
        if (bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b exp 1", bus.wr_ready);
        end
        checks++;
        if (bus.wr_conflict !== 1'b0) begin
            errors++;
            $display("FAIL reset_conflict: got %b exp 0", bus.wr_conflict);
        end
        checks++;
        if (bus.rd_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rd: got %h exp 0000", bus.rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        logic [7:0] exp_now;
`ifdef REGFILE_BYPASS_EN
        exp_now = 8'hA5;
`else
        exp_now = 8'h00;
`endif
        set_wr(2'b01, 4'd0, 8'h00, 4'd3, 8'hA5);
        bus.rd_addr = {4'd3, 4'd3};
        #1;
        checks++;
        if (bus.rd_data[7:0] !== exp_now) begin
            errors++;
            $display("FAIL write_same_cycle: got %h exp %h",
                     bus.rd_data[7:0], exp_now);
        end
        tick();
        set_wr(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
        #1;
        checks++;
        if (bus.rd_data !== 16'hA5A5) begin
            errors++;
            $display("FAIL write_next_cycle: got %h exp a5a5", bus.rd_data);
        end
    endtask

    task automatic test_conflict();
        set_wr(2'b11, 4'd5, 8'h22, 4'd5, 8'h11);
        bus.rd_addr = {4'd5, 4'd5};
        tick();
        set_wr(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
        #1;
        checks++;
        if (bus.wr_conflict !== 1'b1) begin
            errors++;
            $display("FAIL conflict_flag: got %b exp 1", bus.wr_conflict);
        end
        checks++;
        if (bus.rd_data !== 16'h1111) begin
            errors++;
            $display("FAIL conflict_data: got %h exp 1111", bus.rd_data);
        end
        tick();
        checks++;
        if (bus.wr_conflict !== 1'b0) begin
            errors++;
            $display("FAIL conflict_pulse: got %b exp 0", bus.wr_conflict);
        end
        // Two ports on different addresses: no conflict, both stored.
        set_wr(2'b11, 4'd9, 8'h99, 4'd8, 8'h88);
        bus.rd_addr = {4'd9, 4'd8};
        tick();
        set_wr(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
        #1;
        checks++;
        if (bus.wr_conflict !== 1'b0 || bus.rd_data !== 16'h9988) begin
            errors++;
            $display("FAIL dual_write: got conf=%b data=%h exp conf=0 data=9988",
                     bus.wr_conflict, bus.rd_data);
        end
    endtask

    task automatic test_zero_reg();
        set_wr(2'b11, 4'd0, 8'hEE, 4'd0, 8'hFF);
        bus.rd_addr = {4'd0, 4'd0};
        #1;
        checks++;
        if (bus.rd_data !== 16'h0000 || bus.wr_conflict !== 1'b0) begin
            errors++;
            $display("FAIL zero_same_cycle: got data=%h conf=%b exp 0000/0",
                     bus.rd_data, bus.wr_conflict);
        end
        tick();
        set_wr(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
        #1;
        checks++;
        if (bus.rd_data !== 16'h0000) begin
            errors++;
            $display("FAIL zero_after: got %h exp 0000", bus.rd_data);
        end
    endtask

    task automatic test_clear();
        int n;
        for (int a = 0; a < 16; a += 2)
            begin
                set_wr(2'b11, 4'(a + 1), 8'((a + 1) * 17),
                       4'(a), 8'(a * 17));
                tick();
            end
        set_wr(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
        bus.rd_addr = {4'd15, 4'd6};
        #1;
        checks++;
        if (bus.rd_data !== 16'hFF66) begin
            errors++;
            $display("FAIL fill: got %h exp ff66", bus.rd_data);
        end
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        n = 0;
        while (bus.clear_busy === 1'b1 && n < 40) begin
            n++;
            if (n == 1) begin
                set_wr(2'b01, 4'd0, 8'h00, 4'd2, 8'h77);
                bus.rd_addr = {4'd15, 4'd2};
                #1;
                checks++;
                if (bus.wr_ready !== 1'b0 || bus.rd_data !== 16'hFF22) begin
                    errors++;
                    $display("FAIL sweep_start: got rdy=%b data=%h exp 0/ff22",
                             bus.wr_ready, bus.rd_data);
                end
            end
            if (n == 2)
                set_wr(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
            tick();
        end
        checks++;
        if (n !== 15) begin
            errors++;
            $display("FAIL clear_cycles: got %0d exp 15", n);
        end
        checks++;
        if (bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_ready: got %b exp 1", bus.wr_ready);
        end
        for (int a = 0; a < 16; a++) begin
            bus.rd_addr = {4'(a), 4'(a)};
            #1;
            checks++;
            if (bus.rd_data !== 16'h0000) begin
                errors++;
                $display("FAIL cleared[%0d]: got %h exp 0000", a, bus.rd_data);
            end
        end
    endtask

    task automatic test_clk_en();
        int n;
        set_wr(2'b01, 4'd0, 8'h00, 4'd4, 8'h44);
        bus.clear_req = 1'b1;
        tick();
        set_wr(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
        bus.clear_req = 1'b0;
        bus.rd_addr = {4'd4, 4'd4};
        #1;
        checks++;
        if (bus.clear_busy !== 1'b1 || bus.rd_data !== 16'h4444) begin
            errors++;
            $display("FAIL write_with_clear: got busy=%b data=%h exp 1/4444",
                     bus.clear_busy, bus.rd_data);
        end
        n = 0;
        while (bus.clear_busy === 1'b1 && n < 60) begin
            n++;
            if (n == 5) clk_en = 1'b0;
            if (n == 8) clk_en = 1'b1;
            tick();
        end
        clk_en = 1'b1;
        checks++;
        if (n !== 18) begin
            errors++;
            $display("FAIL gated_cycles: got %0d exp 18", n);
        end
        #1;
        checks++;
        if (bus.rd_data !== 16'h0000) begin
            errors++;
            $display("FAIL gated_entry4: got %h exp 0000", bus.rd_data);
        end
    endtask

    task automatic test_reset_mid_sweep();
        set_wr(2'b01, 4'd0, 8'h00, 4'd9, 8'h5A);
        tick();
        set_wr(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        tick();
        bus.rd_addr = {4'd9, 4'd9};
        #1;
        checks++;
        if (bus.clear_busy !== 1'b1 || bus.rd_data !== 16'h5A5A) begin
            errors++;
            $display("FAIL pre_reset: got busy=%b data=%h exp 1/5a5a",
                     bus.clear_busy, bus.rd_data);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.clear_busy !== 1'b0 || bus.wr_ready !== 1'b1
            || bus.rd_data !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b rdy=%b data=%h exp 0/1/0000",
                     bus.clear_busy, bus.wr_ready, bus.rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
`ifdef REGFILE_BYPASS_EN
        set_wr(2'b01, 4'd0, 8'h00, 4'd7, 8'h3C);
        bus.rd_addr = {4'd7, 4'd7};
        #1;
        checks++;
        if (bus.rd_data !== 16'h3C3C) begin
            errors++;
            $display("FAIL bypass: got %h exp 3c3c", bus.rd_data);
        end
        set_wr(2'b11, 4'd7, 8'hC3, 4'd7, 8'h3C);
        #1;
        checks++;
        if (bus.rd_data !== 16'h3C3C) begin
            errors++;
            $display("FAIL bypass_prio: got %h exp 3c3c", bus.rd_data);
        end
        tick();
        set_wr(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
`endif
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_write();
        test_conflict();
        test_zero_reg();
        test_clear();
        test_clk_en();
        test_reset_mid_sweep();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
